// File: rtl/imem_pkg.sv
// imem_pkg: shared instruction-store constants, loader state encoding and big-endian byte select
package imem_pkg;
  localparam int MEM_BYTES      = 16384;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } ldr_state_t;
  // Lane 0 is the most significant byte, matching fetch's {mem[PC], .., mem[PC+3]}
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[8*(3-idx) +: 8];
  endfunction
endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words into the byte-wide instruction store, holding the cpu meanwhile
module imem_loader #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_word,
  input  logic              load_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);
  import imem_pkg::*;
  ldr_state_t        state;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] base;
  logic [31:0]       word;
  logic              last;
  logic [ADDR_W:0]   end_addr;
  logic              in_range;
  // One extra bit keeps the end-of-word address from wrapping near the top of the address space
  assign end_addr = {1'b0, load_addr} + (ADDR_W+1)'(BYTES_PER_WORD-1);
  assign in_range = (load_addr[1:0] == 2'b00) && (end_addr <= (ADDR_W+1)'(MEM_BYTES-1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_idx   <= 2'd0;
      base       <= '0;
      word       <= '0;
      last       <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (load_start) begin
          state      <= S_ACCEPT;
          word_count <= '0;
        end
        S_ACCEPT: if (load_valid) begin
          base     <= load_addr;
          word     <= load_word;
          last     <= load_last;
          byte_idx <= 2'd0;
          state    <= in_range ? S_WRITE : S_ERR;
        end
        S_WRITE: begin
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            word_count <= (&word_count) ? word_count : word_count + 16'd1;
            state      <= last ? S_DONE : S_ACCEPT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign load_ready = state == S_ACCEPT;
  assign busy       = state == S_ACCEPT || state == S_WRITE;
  assign cpu_hold   = busy || state == S_ERR;
  assign done       = state == S_DONE;
  assign err        = state == S_ERR;
  assign mem_we     = state == S_WRITE;
  assign mem_addr   = mem_we ? base + ADDR_W'(byte_idx) : '0;
  assign mem_wdata  = mem_we ? byte_sel(word, byte_idx) : 8'h00;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the instruction-store loader against a byte-array store model
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_addr = '0, load_word = '0;
  logic        load_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] word_count;
  logic [7:0]  mem [0:16383];
  int          nvec = 0, nerr = 0, we_cnt = 0;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_addr(load_addr), .load_word(load_word),
    .load_last(load_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) begin
    mem[mem_addr[13:0]] <= mem_wdata;
    we_cnt <= we_cnt + 1;
  end

  function automatic logic [31:0] fetch(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic start();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] w, input logic l);
    int k;
    load_addr = a; load_word = w; load_last = l; load_valid = 1'b1;
    for (k = 0; k < 20 && !load_ready; k++) @(negedge clk);
    if (!load_ready) begin nvec++; nerr++; $display("FAIL send_timeout ready=%b want 1", load_ready); end
    @(negedge clk); load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if ({load_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0) begin nerr++; $display("FAIL reset_flags got=%b want 000000", {load_ready, mem_we, cpu_hold, busy, done, err}); end
    nvec++; if ({word_count, mem_addr, mem_wdata} !== 56'h0) begin nerr++; $display("FAIL reset_data wc=%h addr=%h wd=%h want 0", word_count, mem_addr, mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++; if (cpu_hold !== 1'b0) begin nerr++; $display("FAIL idle_hold got=%b want 0", cpu_hold); end
  endtask

  task automatic test_single();
    logic [31:0] w = 32'h48080000;
    start();
    nvec++; if ({load_ready, busy, cpu_hold} !== 3'b111) begin nerr++; $display("FAIL accept_flags got=%b want 111", {load_ready, busy, cpu_hold}); end
    send(32'd100, w, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nvec++; if ({mem_we, load_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'(100 + i), 8'(w >> (24 - 8*i))}) begin nerr++; $display("FAIL single_byte%0d we=%b rdy=%b addr=%0d data=%h want we=1 rdy=0 addr=%0d data=%h", i, mem_we, load_ready, mem_addr, mem_wdata, 100 + i, 8'(w >> (24 - 8*i))); end
      @(negedge clk);
    end
    nvec++; if ({done, cpu_hold, busy, mem_we} !== 4'b1000) begin nerr++; $display("FAIL single_done got=%b want 1000", {done, cpu_hold, busy, mem_we}); end
    nvec++; if (word_count !== 16'd1) begin nerr++; $display("FAIL single_count got=%0d want 1", word_count); end
    nvec++; if (fetch(100) !== w) begin nerr++; $display("FAIL single_fetch got=%h want %h", fetch(100), w); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, rdy = 0, hs = 0;
    logic [7:0] exp [8] = '{8'h24, 8'h13, 8'h00, 8'h05, 8'h24, 8'h14, 8'h00, 8'h0A};
    start();
    load_addr = 32'd200; load_word = 32'h24130005; load_last = 1'b0; load_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc++;
      if (load_ready) begin rdy++; hs++; end
      @(negedge clk);
      if (hs == 1) begin load_addr = 32'd204; load_word = 32'h2414000A; load_last = 1'b1; end
    end
    load_valid = 1'b0;
    nvec++; if (done !== 1'b1 || cyc != 10) begin nerr++; $display("FAIL b2b_cycles done=%b cycles=%0d want done=1 cycles=10", done, cyc); end
    nvec++; if (rdy != 2) begin nerr++; $display("FAIL b2b_ready_cycles got=%0d want 2", rdy); end
    nvec++; if (word_count !== 16'd2) begin nerr++; $display("FAIL b2b_count got=%0d want 2", word_count); end
    for (int i = 0; i < 8; i++) begin
      nvec++; if (mem[200 + i] !== exp[i]) begin nerr++; $display("FAIL b2b_mem%0d got=%h want %h", 200 + i, mem[200 + i], exp[i]); end
    end
  endtask

  task automatic test_misaligned();
    int w0;
    start();
    w0 = we_cnt;
    send(32'd202, 32'hCAFEF00D, 1'b1);
    nvec++; if ({err, cpu_hold, busy, done, mem_we} !== 5'b11000) begin nerr++; $display("FAIL misaligned_err got=%b want 11000", {err, cpu_hold, busy, done, mem_we}); end
    repeat (3) @(negedge clk);
    nvec++; if (we_cnt != w0 || err !== 1'b1) begin nerr++; $display("FAIL misaligned_nowrite strobes=%0d err=%b want 0 err=1", we_cnt - w0, err); end
    start();
    nvec++; if ({err, cpu_hold, load_ready, word_count} !== {3'b011, 16'd0}) begin nerr++; $display("FAIL misaligned_clear err=%b hold=%b rdy=%b wc=%0d want 0 1 1 0", err, cpu_hold, load_ready, word_count); end
  endtask

  task automatic test_range();
    logic [31:0] w = 32'hA1B2C3D4;
    int w0 = we_cnt;
    send(32'd16381, w, 1'b1);
    nvec++; if ({err, cpu_hold, mem_we} !== 3'b110) begin nerr++; $display("FAIL range_err got=%b want 110", {err, cpu_hold, mem_we}); end
    nvec++; if (we_cnt != w0) begin nerr++; $display("FAIL range_nowrite strobes=%0d want 0", we_cnt - w0); end
    start();
    send(32'd16380, w, 1'b1);
    repeat (3) @(negedge clk);
    nvec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'd16383, 8'hD4}) begin nerr++; $display("FAIL range_top_byte we=%b addr=%0d data=%h want 1 16383 d4", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    nvec++; if ({done, err} !== 2'b10 || fetch(16380) !== w) begin nerr++; $display("FAIL range_top_word done=%b err=%b word=%h want 1 0 %h", done, err, fetch(16380), w); end
  endtask

  task automatic test_ignored_restart();
    start();
    send(32'd400, 32'h11223344, 1'b0);
    load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    nvec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'd401, 8'h22}) begin nerr++; $display("FAIL restart_write we=%b addr=%0d data=%h want 1 401 22", mem_we, mem_addr, mem_wdata); end
    repeat (3) @(negedge clk);
    nvec++; if ({load_ready, word_count} !== {1'b1, 16'd1}) begin nerr++; $display("FAIL restart_count rdy=%b wc=%0d want 1 1", load_ready, word_count); end
    send(32'd404, 32'h55667788, 1'b1);
    repeat (4) @(negedge clk);
    nvec++; if ({done, word_count} !== {1'b1, 16'd2}) begin nerr++; $display("FAIL restart_done done=%b wc=%0d want 1 2", done, word_count); end
    nvec++; if ({fetch(400), fetch(404)} !== 64'h11223344_55667788) begin nerr++; $display("FAIL restart_mem got=%h%h want 1122334455667788", fetch(400), fetch(404)); end
  endtask

  task automatic test_reset_mid();
    start();
    send(32'd300, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    nvec++; if ({mem_we, mem_addr} !== {1'b1, 32'd301}) begin nerr++; $display("FAIL mid_second we=%b addr=%0d want 1 301", mem_we, mem_addr); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++; if ({load_ready, mem_we, cpu_hold, busy, done, err, word_count, mem_addr, mem_wdata} !== 62'h0) begin nerr++; $display("FAIL mid_reset_outputs rdy=%b we=%b hold=%b busy=%b done=%b err=%b wc=%0d addr=%0d wd=%h want all 0", load_ready, mem_we, cpu_hold, busy, done, err, word_count, mem_addr, mem_wdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    nvec++; if (fetch(300) !== 32'hDEADEEEE) begin nerr++; $display("FAIL mid_reset_mem got=%h want deadeeee", fetch(300)); end
    nvec++; if ({mem_we, done, busy} !== 3'b000) begin nerr++; $display("FAIL mid_reset_idle got=%b want 000", {mem_we, done, busy}); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'hEE;
    test_reset();
    test_single();
    test_back_to_back();
    test_misaligned();
    test_range();
    test_ignored_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
